// File: rtl/spiral_frame_wrapper.sv
// Frame buffer around a streaming Spiral transform core: collects one input frame from DMA,
// streams it into the core, captures the core's output frame and drains it back to DMA.
module spiral_frame_wrapper #(
    parameter int LANES          = 4,
    parameter int SAMPLE_W       = 8,
    parameter int FRAME_WORDS    = 32,
    parameter int OVERLAP        = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*SAMPLE_W-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [LANES*SAMPLE_W-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      core_next,
    output logic [LANES*SAMPLE_W-1:0] core_x,
    input  logic                      core_next_out,
    input  logic [LANES*SAMPLE_W-1:0] core_y,
    output logic                      dev_ready,
    output logic                      dev_busy,
    output logic                      frame_done,
    output logic [CNT_W-1:0]          frame_count,
    output logic                      err_timeout,
    output logic                      err_spurious
);
    localparam int W  = LANES * SAMPLE_W;
    localparam int AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL     = CW'(FRAME_WORDS);
    localparam logic [AW-1:0] CAP_LAST = AW'(FRAME_WORDS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FILL, STREAM, WAIT, CAPTURE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [W-1:0]  in_buf  [FRAME_WORDS];
    logic [W-1:0]  out_buf [FRAME_WORDS];
    logic [CW-1:0] in_cnt, in_cnt_nxt, str_cnt, out_cnt;
    logic [AW-1:0] cap_cnt, rd_ptr;
    logic [TW-1:0] wait_cnt;
    logic          init_done;
    logic          accept, pop, last_pop, stream_end, cap_end, timeout_hit;

    // init_done holds s_ready low for the first cycle after reset so every output reads 0 there
    always_comb begin
        s_ready = 1'b0;
        if (init_done && (in_cnt < FULL)) begin
            if (state == IDLE || state == FILL || (OVERLAP != 0 && state == DRAIN))
                s_ready = 1'b1;
        end
        accept     = s_valid & s_ready;
        in_cnt_nxt = in_cnt + CW'(accept);

        m_valid  = (state == DRAIN) && (out_cnt != '0);
        m_data   = m_valid ? out_buf[rd_ptr] : '0;
        pop      = m_valid & m_ready;
        last_pop = pop && (out_cnt == CW'(1));

        core_next = (state == STREAM) && (str_cnt == '0);
        core_x    = '0;
        if (state == STREAM && str_cnt != '0)
            core_x = in_buf[AW'(str_cnt - CW'(1))];

        stream_end  = (state == STREAM) && (str_cnt == FULL);
        cap_end     = (state == CAPTURE) && (cap_cnt == CAP_LAST);
        timeout_hit = (state == WAIT) && !core_next_out && (wait_cnt == TO_LAST);
        dev_busy    = (state == STREAM) || (state == WAIT) || (state == CAPTURE);
    end

    assign dev_ready = s_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FILL;
            FILL:    if (in_cnt == FULL) state_nxt = STREAM;
            STREAM:  if (stream_end) state_nxt = WAIT;
            WAIT: begin
                if (core_next_out)    state_nxt = CAPTURE;
                else if (timeout_hit) state_nxt = IDLE;
            end
            CAPTURE: if (cap_end) state_nxt = DRAIN;
            DRAIN: begin
                // an overlapped input frame may already be complete when the output frame empties
                if (last_pop) begin
                    if (in_cnt_nxt == FULL)     state_nxt = STREAM;
                    else if (in_cnt_nxt != '0)  state_nxt = FILL;
                    else                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            init_done    <= 1'b0;
            in_cnt       <= '0;
            str_cnt      <= '0;
            wait_cnt     <= '0;
            cap_cnt      <= '0;
            out_cnt      <= '0;
            rd_ptr       <= '0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= 1'b1;
            in_cnt    <= stream_end ? '0 : in_cnt_nxt;
            str_cnt   <= (state == STREAM && !stream_end) ? str_cnt + CW'(1) : '0;
            wait_cnt  <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
            cap_cnt   <= (state == CAPTURE) ? cap_cnt + AW'(1) : '0;

            if (cap_end)
                out_cnt <= FULL;
            else if (pop)
                out_cnt <= out_cnt - CW'(1);

            if (state == CAPTURE)
                rd_ptr <= '0;
            else if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            frame_done <= last_pop;
            if (last_pop)
                frame_count <= frame_count + CNT_W'(1);

            if (timeout_hit)
                err_timeout <= 1'b1;
            if (core_next_out && state != WAIT)
                err_spurious <= 1'b1;
        end
    end

    // Buffers carry no reset; the counters alone decide what is valid
    always_ff @(posedge clk) begin
        if (accept)
            in_buf[AW'(in_cnt)] <= s_data;
        if (state == CAPTURE)
            out_buf[cap_cnt] <= core_y;
    end

endmodule

// File: tb/tb_spiral_frame_wrapper.sv
// Self-checking bench for spiral_frame_wrapper with a loopback core model (40-cycle latency).
module tb_spiral_frame_wrapper;
    localparam int W        = 32;
    localparam int FW       = 32;
    localparam int CORE_LAT = 40;
    localparam int TIMEOUT  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          core_next_out;
    logic [W-1:0]  core_y;

    logic          s_ready, m_valid, core_next, dev_ready, dev_busy, frame_done;
    logic          err_timeout, err_spurious;
    logic [W-1:0]  m_data, core_x;
    logic [15:0]   frame_count;

    logic          ov_s_ready, ov_m_valid, ov_core_next, ov_dev_ready, ov_dev_busy, ov_frame_done;
    logic          ov_err_timeout, ov_err_spurious;
    logic [W-1:0]  ov_m_data, ov_core_x;
    logic [15:0]   ov_frame_count;

    spiral_frame_wrapper dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .core_next(core_next), .core_x(core_x),
        .core_next_out(core_next_out), .core_y(core_y),
        .dev_ready(dev_ready), .dev_busy(dev_busy), .frame_done(frame_done),
        .frame_count(frame_count), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    spiral_frame_wrapper #(.OVERLAP(1)) dut_ov (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(ov_s_ready),
        .m_data(ov_m_data), .m_valid(ov_m_valid), .m_ready(m_ready),
        .core_next(ov_core_next), .core_x(ov_core_x),
        .core_next_out(core_next_out), .core_y(core_y),
        .dev_ready(ov_dev_ready), .dev_busy(ov_dev_busy), .frame_done(ov_frame_done),
        .frame_count(ov_frame_count), .err_timeout(ov_err_timeout), .err_spurious(ov_err_spurious)
    );

    // Loopback core: core_y and core_next_out replay core_x / core_next CORE_LAT cycles later
    logic [W-1:0] x_pipe  [CORE_LAT];
    logic         nx_pipe [CORE_LAT];
    logic         core_en = 1'b1;
    logic         spur_inj = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CORE_LAT; i++) begin
                x_pipe[i]  <= '0;
                nx_pipe[i] <= 1'b0;
            end
        end else begin
            x_pipe[0]  <= core_x;
            nx_pipe[0] <= core_next;
            for (int i = 1; i < CORE_LAT; i++) begin
                x_pipe[i]  <= x_pipe[i-1];
                nx_pipe[i] <= nx_pipe[i-1];
            end
        end
    end

    assign core_y        = x_pipe[CORE_LAT-1];
    assign core_next_out = (nx_pipe[CORE_LAT-1] & core_en) | spur_inj;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] base;
        logic [W-1:0] step;
        bit           toggle_ready;
        bit           gaps;
        bit           spur;
        logic [15:0]  exp_count;
        bit           exp_spur;
        bit           exp_to;
    } frame_vec_t;

    frame_vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] allOuts();
        return {40'd0, s_ready, m_valid, core_next, core_x, m_data, dev_ready, dev_busy,
                frame_done, frame_count, err_timeout, err_spurious};
    endfunction

    task automatic applyReset();
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; spur_inj = 1'b0; s_data = '0;
        tick();
        rst = 1'b1;
    endtask

    // Push one full frame in and return the cycle where core_next was seen (-1 if never)
    task automatic fillFrame(input logic [W-1:0] base, input logic [W-1:0] step, output int cn);
        int sent;
        int t0;
        sent = 0;
        t0 = cyc;
        cn = -1;
        m_ready = 1'b0;
        while (cn < 0 && (cyc - t0) < 200) begin
            if (core_next) begin
                cn = cyc;
            end else begin
                if (sent < FW) begin
                    s_valid = 1'b1;
                    s_data  = base + step * W'(sent);
                    if (s_ready) sent++;
                end else begin
                    s_valid = 1'b0;
                    s_data  = '0;
                end
                tick();
            end
        end
        s_valid = 1'b0;
        checkOutput("fill core_next seen", (cn >= 0), 1'b1);
    endtask

    // Run one whole frame through the loopback and compare everything that comes out
    task automatic applyStimulus(input frame_vec_t v, input string tag);
        logic [W-1:0] words [FW];
        int  sent, pops, dones, last_acc, cn_cyc, t0, stab_err, busy_err;
        logic prev_stall;
        logic [W-1:0] prev_data;
        bit  done;
        for (int i = 0; i < FW; i++) words[i] = v.base + v.step * W'(i);
        sent = 0; pops = 0; dones = 0; last_acc = -100; cn_cyc = -1;
        stab_err = 0; busy_err = 0; prev_stall = 1'b0; prev_data = '0; done = 1'b0;
        t0 = cyc;
        while (!done && (cyc - t0) < 3000) begin
            spur_inj = 1'b0;
            if (core_next && cn_cyc < 0) begin
                cn_cyc = cyc;
                if (v.spur) spur_inj = 1'b1;
            end
            if (frame_done) begin
                dones++;
                done = 1'b1;
            end
            if ((dev_busy || m_valid) && s_ready) busy_err++;
            if (prev_stall && m_valid && (m_data !== prev_data)) stab_err++;
            m_ready = v.toggle_ready ? cyc[0] : 1'b1;
            if (m_valid && m_ready) begin
                if (pops < FW)
                    checkOutput($sformatf("%s m_data[%0d]", tag, pops), m_data, words[pops]);
                pops++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (sent < FW) begin
                s_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_data  = words[sent];
                if (s_valid && s_ready) begin
                    sent++;
                    if (sent == FW) last_acc = cyc;
                end
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b0; spur_inj = 1'b0;
        repeat (3) begin
            tick();
            if (frame_done) dones++;
        end
        checkOutput({tag, " frame_done pulses"}, dones, 1);
        checkOutput({tag, " pop count"}, pops, FW);
        checkOutput({tag, " core_next latency"}, cn_cyc - last_acc, 2);
        checkOutput({tag, " frame_count"}, frame_count, v.exp_count);
        checkOutput({tag, " err flags"}, {err_timeout, err_spurious}, {v.exp_to, v.exp_spur});
        checkOutput({tag, " m_data stable"}, stab_err, 0);
        checkOutput({tag, " s_ready low while busy"}, busy_err, 0);
        checkOutput({tag, " idle after"}, {s_ready, dev_busy, m_valid}, 3'b100);
    endtask

    initial begin
        int cn, t0, dones, ov_acc, s0_err;
        vecs[0] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
        vecs[1] = '{32'hA5A5_0000, 32'h0101_0101, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0001, 32'h1357_9BDF, 1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0};

        applyReset();
        checkOutput("reset outputs", allOuts(), '0);
        tick();
        checkOutput("s_ready after reset", {s_ready, dev_ready}, 2'b11);

        for (int i = 0; i < 4; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Core never answers: timeout exactly TIMEOUT cycles after WAIT entry
        applyReset();
        core_en = 1'b0;
        fillFrame(32'h0000_1000, 32'h0000_0003, cn);
        while (cyc < cn + FW + 1 + TIMEOUT - 1) tick();
        checkOutput("timeout not early", {err_timeout, dev_busy}, 2'b01);
        tick();
        checkOutput("timeout set", {err_timeout, dev_busy, frame_done, frame_count}, {1'b1, 1'b0, 1'b0, 16'd0});
        core_en = 1'b1;
        applyStimulus('{32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1}, "after_timeout");

        // Reset for one cycle in the middle of CAPTURE
        applyReset();
        fillFrame(32'h2000_0000, 32'h0000_0011, cn);
        t0 = cyc;
        while (!core_next_out && (cyc - t0) < 100) tick();
        checkOutput("core_next_out seen", core_next_out, 1'b1);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("reset mid-capture outputs", allOuts(), '0);
        dones = 0;
        repeat (60) begin
            tick();
            if (frame_done) dones++;
        end
        checkOutput("no frame_done after reset", dones, 0);
        applyStimulus('{32'h0BAD_F00D, 32'h0000_0101, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0}, "after_reset");

        // Overlap: next frame offered while the output frame is stalled in DRAIN
        applyReset();
        fillFrame(32'h0000_3000, 32'h0000_0001, cn);
        t0 = cyc;
        while (!m_valid && (cyc - t0) < 200) tick();
        checkOutput("drain reached", m_valid, 1'b1);
        ov_acc = 0;
        s0_err = 0;
        m_ready = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (s_ready) s0_err++;
            if (ov_acc < FW) begin
                s_valid = 1'b1;
                s_data  = 32'h0000_4000 + W'(ov_acc);
                if (ov_s_ready) ov_acc++;
            end else begin
                s_valid = 1'b0;
            end
            tick();
        end
        s_valid = 1'b0;
        checkOutput("overlap accepted in drain", ov_acc, FW);
        checkOutput("no-overlap s_ready in drain", s0_err, 0);
        checkOutput("overlap s_ready when full", ov_s_ready, 1'b0);
        m_ready = 1'b1;
        t0 = cyc;
        while (m_valid && (cyc - t0) < 100) tick();
        m_ready = 1'b0;
        checkOutput("overlap after last pop", {ov_core_next, ov_dev_busy, ov_frame_done, ov_frame_count},
                    {1'b1, 1'b1, 1'b1, 16'd1});
        checkOutput("no-overlap after last pop", {core_next, dev_busy, frame_done, frame_count, s_ready},
                    {1'b0, 1'b0, 1'b1, 16'd1, 1'b1});
        applyReset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spiral_frame_wrapper.md
Name: spiral_frame_wrapper

Overview:
Parametrised frame buffer wrapping a streaming Spiral-generated transform core (next/next_out protocol) between a DMA write stream and a DMA read stream. It collects one frame of FRAME_WORDS words and streams it into the core on consecutive cycles. It captures the core's full output frame unconditionally and drains it under valid/ready backpressure. Adds backpressure on both sides, optional input/output overlap, a core-response timeout, error flags and a frame counter.

Parameters:
LANES, 4, samples per word; lane 0 occupies the LSBs.
SAMPLE_W, 8, bits per sample.
FRAME_WORDS, 32, words per frame (>=2); sizes both internal buffers.
OVERLAP, 0, 1 = accept the next input frame while the output frame drains.
TIMEOUT_CYCLES, 1024, maximum WAIT cycles for core_next_out.
CNT_W, 16, frame_count width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
s_data  in  LANES*SAMPLE_W  DMA write data
s_valid  in  1  write data valid
s_ready  out  1  wrapper accepts s_data
m_data  out  LANES*SAMPLE_W  DMA read data
m_valid  out  1  m_data valid
m_ready  in  1  DMA consumes m_data
core_next  out  1  one-cycle start pulse to core
core_x  out  LANES*SAMPLE_W  core input word
core_next_out  in  1  core output-start pulse
core_y  in  LANES*SAMPLE_W  core output word
dev_ready  out  1  equals s_ready
dev_busy  out  1  core frame in flight
frame_done  out  1  one-cycle pulse, frame fully drained
frame_count  out  CNT_W  completed frames, wraps
err_timeout  out  1  sticky
err_spurious  out  1  sticky

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; all counters 0. Every output is 0 (s_ready, m_valid, core_next, core_x, m_data, dev_ready, dev_busy, frame_done, frame_count, err_*). Reset mid-frame discards both buffers with no completion pulse.
- States: IDLE, FILL, STREAM, WAIT, CAPTURE, DRAIN.
- Accept = s_valid & s_ready; each accept writes in_buf[in_cnt] and increments in_cnt.
- s_ready = (in_cnt < FRAME_WORDS) & (state in IDLE/FILL, or OVERLAP=1 & state=DRAIN).
- IDLE -> FILL on first accept.
- FILL -> STREAM the cycle after in_cnt reaches FRAME_WORDS.
- STREAM:
  - core_next=1 in the first STREAM cycle only.
  - core_x = in_buf[0..FRAME_WORDS-1] on the FRAME_WORDS consecutive cycles starting the cycle after core_next; core_x=0 otherwise.
  - After the last word: in_cnt=0 -> WAIT.
- WAIT:
  - Cycle counter starts at 0.
  - core_next_out -> CAPTURE.
  - Counter reaches TIMEOUT_CYCLES -> set err_timeout, go to IDLE; no frame_done, frame_count unchanged.
- CAPTURE:
  - core_y is sampled into out_buf on the FRAME_WORDS consecutive cycles starting the cycle after core_next_out; there is no stall.
  - After the last word: out_cnt=FRAME_WORDS -> DRAIN.
- DRAIN:
  - m_valid = (out_cnt>0); m_data = out_buf[rd_ptr] and is held stable while m_valid & ~m_ready.
  - The last pop (m_valid & m_ready with out_cnt=1) produces frame_done=1 for one cycle and frame_count+1 (wraps at 2^CNT_W).
  - Next state on that pop: STREAM if in_cnt=FRAME_WORDS, else FILL if in_cnt>0, else IDLE.
- core_next_out outside WAIT (including during CAPTURE, or late after a timeout) sets err_spurious and is otherwise ignored.
- Error flags clear only on reset.
- dev_busy = state in STREAM, WAIT, CAPTURE.
- Data is passed bit-exact; no arithmetic on samples.
- Latency from the last accepted input word to core_next: 2 cycles.

Test Plan:
- Defaults with a loopback core model (core_y = core_x delayed; core_next_out 40 cycles after core_next): send words 0x00000000..0x0000001F with m_ready=1 -> m_data returns 0x00..0x1F in order; frame_done once; frame_count=1; s_ready=0 from STREAM until IDLE.
- Toggle m_ready 1/0 each cycle and hold s_valid low for random gaps -> data intact; m_data stable while stalled; exactly 32 pops.
- Core model never asserts core_next_out -> err_timeout=1 exactly 1024 cycles after WAIT entry; state returns to IDLE; frame_count=0; a following good frame completes with frame_count=1.
- OVERLAP=1, m_ready=0 during DRAIN, 32 new words offered -> all 32 accepted during DRAIN; after the final pop, state=STREAM and core_next pulses; OVERLAP=0 same stimulus -> s_ready=0 throughout DRAIN.
- core_next_out injected during STREAM -> err_spurious=1; frame still completes correctly.
- Assert rst=0 for one cycle mid-CAPTURE -> all outputs 0 next cycle; no frame_done; a fresh frame then completes normally.
